// File: rtl/llc_read_arbiter.sv
// llc_read_arbiter: shares one AXI read channel between I-side (S1) and D-side (S2) line fills.
// Define L2_ARB_RR_EN for round-robin arbitration; default is fixed S2-over-S1 priority.
module llc_read_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_WIDTH = 512,
    parameter int ID_WIDTH   = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] S1_R_ADDR,
    input  logic                  S1_R_ADDR_VALID,
    output logic [LINE_WIDTH-1:0] S1_R_DATA,
    output logic                  S1_R_DATA_VALID,
    input  logic [ADDR_WIDTH-1:0] S2_R_ADDR,
    input  logic                  S2_R_ADDR_VALID,
    output logic [LINE_WIDTH-1:0] S2_R_DATA,
    output logic                  S2_R_DATA_VALID,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  protocol_err
);
    localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
    localparam int BW = $clog2(BEATS);
    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  grant_q, grant_d;
    logic [BW-1:0]         beat_q, beat_d, word;
    logic [LINE_WIDTH-1:0] line_q, line_d, s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic                  err_q, err_d;
    logic                  any_req, pick_s2;

    assign any_req = S1_R_ADDR_VALID | S2_R_ADDR_VALID;

`ifdef L2_ARB_RR_EN
    // last_grant_q: 0 = S1 granted last, 1 = S2 granted last
    logic last_grant_q, last_grant_d;
    assign pick_s2 = S2_R_ADDR_VALID & (~S1_R_ADDR_VALID | ~last_grant_q);
    assign last_grant_d = (state_q == IDLE && any_req) ? pick_s2 : last_grant_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_grant_q <= 1'b0;
        else       last_grant_q <= last_grant_d;
    end
`else
    assign pick_s2 = S2_R_ADDR_VALID;
`endif

    // critical-word-first: beat n lands at (start word + n) wrapped within the line
    assign word = addr_q[OFF +: BW] + beat_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        line_d    = line_q;
        s1_data_d = s1_data_q;
        s2_data_d = s2_data_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (any_req) begin
                grant_d = pick_s2;
                addr_d  = pick_s2 ? S2_R_ADDR : S1_R_ADDR;
                state_d = AR;
            end
            AR: if (m_axi_arready) state_d = R;
            R: if (m_axi_rvalid) begin
                line_d[word*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                beat_d = beat_q + BW'(1);
                if (m_axi_rlast != (beat_q == LAST)) err_d = 1'b1;
                // publish the line on the final beat so data is valid alongside the RESP pulse
                if (beat_q == LAST) begin
                    state_d = RESP;
                    if (grant_q) s2_data_d = line_d;
                    else         s1_data_d = line_d;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            grant_q   <= 1'b0;
            beat_q    <= '0;
            line_q    <= '0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            grant_q   <= grant_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            err_q     <= err_d;
        end
    end

    assign m_axi_arvalid   = state_q == AR;
    assign m_axi_rready    = state_q == R;
    assign m_axi_arid      = ID_WIDTH'(grant_q);
    assign m_axi_araddr    = addr_q & ~LOW_MASK;
    assign S1_R_DATA_VALID = state_q == RESP && !grant_q;
    assign S2_R_DATA_VALID = state_q == RESP && grant_q;
    assign S1_R_DATA       = s1_data_q;
    assign S2_R_DATA       = s2_data_q;
    assign protocol_err    = err_q;
endmodule

// File: tb/tb_llc_read_arbiter.sv
// tb_llc_read_arbiter: randomized self-checking bench with an AXI read-slave driver and a line-level model.
module tb_llc_read_arbiter;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [63:0]  S1_R_ADDR = '0, S2_R_ADDR = '0;
    logic         S1_R_ADDR_VALID = 1'b0, S2_R_ADDR_VALID = 1'b0;
    logic [511:0] S1_R_DATA, S2_R_DATA;
    logic         S1_R_DATA_VALID, S2_R_DATA_VALID;
    logic [12:0]  m_axi_arid;
    logic [63:0]  m_axi_araddr;
    logic         m_axi_arvalid, m_axi_rready, protocol_err;
    logic         m_axi_arready = 1'b0, m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0;
    logic [63:0]  m_axi_rdata = '0;

    llc_read_arbiter dut (
        .clk(clk), .reset(reset),
        .S1_R_ADDR(S1_R_ADDR), .S1_R_ADDR_VALID(S1_R_ADDR_VALID),
        .S1_R_DATA(S1_R_DATA), .S1_R_DATA_VALID(S1_R_DATA_VALID),
        .S2_R_ADDR(S2_R_ADDR), .S2_R_ADDR_VALID(S2_R_ADDR_VALID),
        .S2_R_DATA(S2_R_DATA), .S2_R_DATA_VALID(S2_R_DATA_VALID),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [63:0]  beat_data [8];
    logic [63:0]  obs_araddr;
    logic [12:0]  obs_arid;
    logic [511:0] obs_line;
    bit           obs_stable, obs_timeout;
    int           obs_lat, obs_p1, obs_p2;

    // Model: beat k of a wrapping burst belongs at line word ((addr/8) + k) mod 8.
    function automatic logic [511:0] expect_line(input logic [63:0] addr);
        logic [511:0] l = '0;
        int start = int'((addr >> 3) % 64'd8);
        for (int k = 0; k < 8; k++) l[((start + k) % 8) * 64 +: 64] = beat_data[k];
        return l;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        S1_R_ADDR_VALID = 1'b0;
        S2_R_ADDR_VALID = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_arready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // AXI slave side of one fill; called at the negedge where the request is already driven.
    // Returns at the negedge one cycle after the completion pulse with the DUT back in IDLE.
    task automatic run_fill(input int ar_stall, input bit gaps, input logic [7:0] rlast_pat, input bit keep_req);
        int k = 0;
        int guard = 0;
        bit tog = 1'b0;
        bit v;
        obs_timeout = 1'b0; obs_stable = 1'b1; obs_lat = -1; obs_p1 = 0; obs_p2 = 0; obs_line = '0;
        for (int lat = 0; ; ) begin
            while (!m_axi_arvalid) begin
                @(negedge clk); lat++;
                if (lat > 20) begin obs_timeout = 1'b1; return; end
            end
            obs_araddr = m_axi_araddr;
            obs_arid = m_axi_arid;
            S1_R_ADDR = rand64();
            S2_R_ADDR = rand64();
            for (int i = 0; i < ar_stall; i++) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata = rand64();
                if (m_axi_rready !== 1'b0) obs_stable = 1'b0;
                @(negedge clk); lat++;
                if (m_axi_araddr !== obs_araddr || m_axi_arid !== obs_arid || m_axi_arvalid !== 1'b1) obs_stable = 1'b0;
            end
            m_axi_rvalid = 1'b0;
            m_axi_arready = 1'b1;
            @(negedge clk); lat++;
            m_axi_arready = 1'b0;
            while (k < 8) begin
                v = !gaps || !tog;
                tog = ~tog;
                m_axi_rvalid = v;
                m_axi_rdata = v ? beat_data[k] : rand64();
                m_axi_rlast = v ? rlast_pat[k] : 1'($urandom_range(0, 1));
                if (m_axi_rready !== 1'b1) obs_stable = 1'b0;
                @(negedge clk); lat++; guard++;
                if (v) k++;
                if (guard > 40) begin m_axi_rvalid = 1'b0; obs_timeout = 1'b1; return; end
            end
            m_axi_rvalid = 1'b0;
            m_axi_rlast = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (S1_R_DATA_VALID === 1'b1) begin obs_p1++; obs_line = S1_R_DATA; if (obs_lat < 0) obs_lat = lat; end
                if (S2_R_DATA_VALID === 1'b1) begin obs_p2++; obs_line = S2_R_DATA; if (obs_lat < 0) obs_lat = lat; end
                if (i == 0 && !keep_req) begin
                    if (obs_arid[0]) S2_R_ADDR_VALID = 1'b0;
                    else S1_R_ADDR_VALID = 1'b0;
                end
                if (i == 0) begin @(negedge clk); lat++; end
            end
            return;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid: got %0b want 0", m_axi_arvalid); end
        total++; if (m_axi_rready !== 1'b0) begin bad++; $display("FAIL reset_rready: got %0b want 0", m_axi_rready); end
        total++; if (m_axi_araddr !== 64'h0 || m_axi_arid !== 13'h0) begin bad++; $display("FAIL reset_ar: got %h/%h want 0/0", m_axi_araddr, m_axi_arid); end
        total++; if (S1_R_DATA !== '0 || S2_R_DATA !== '0) begin bad++; $display("FAIL reset_data: got %h / %h want 0", S1_R_DATA, S2_R_DATA); end
        total++; if (S1_R_DATA_VALID !== 1'b0 || S2_R_DATA_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b%0b want 00", S1_R_DATA_VALID, S2_R_DATA_VALID); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", protocol_err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL idle_no_req: arvalid got %0b want 0", m_axi_arvalid); end
    endtask

    task automatic test_s1_only();
        for (int k = 0; k < 8; k++) beat_data[k] = 64'hA0 + 64'(k);
        S1_R_ADDR = 64'h1000;
        S1_R_ADDR_VALID = 1'b1;
        run_fill(0, 1'b0, 8'h80, 1'b0);
        total++; if (obs_timeout) begin bad++; $display("FAIL s1_timeout: got timeout want completion"); end
        total++; if (obs_araddr !== 64'h1000 || obs_arid !== 13'd0) begin bad++; $display("FAIL s1_ar: got %h/%0d want 1000/0", obs_araddr, obs_arid); end
        total++; if (obs_lat !== 10) begin bad++; $display("FAIL s1_latency: got %0d want 10", obs_lat); end
        total++; if (obs_p1 !== 1 || obs_p2 !== 0) begin bad++; $display("FAIL s1_pulses: got %0d/%0d want 1/0", obs_p1, obs_p2); end
        total++; if (obs_line !== expect_line(64'h1000)) begin bad++; $display("FAIL s1_line: got %h want %h", obs_line, expect_line(64'h1000)); end
        total++; if (S1_R_DATA[64*5 +: 64] !== 64'hA5) begin bad++; $display("FAIL s1_word5: got %h want a5", S1_R_DATA[64*5 +: 64]); end
        total++; if (S2_R_DATA !== '0) begin bad++; $display("FAIL s1_s2_untouched: got %h want 0", S2_R_DATA); end
        total++; if (S1_R_DATA !== expect_line(64'h1000)) begin bad++; $display("FAIL s1_retained: got %h want %h", S1_R_DATA, expect_line(64'h1000)); end
    endtask

    task automatic test_s2_wrap();
        for (int k = 0; k < 8; k++) beat_data[k] = 64'hB0 + 64'(k);
        S2_R_ADDR = 64'h2038;
        S2_R_ADDR_VALID = 1'b1;
        run_fill(0, 1'b0, 8'h80, 1'b0);
        total++; if (obs_araddr !== 64'h2038 || obs_arid !== 13'd1) begin bad++; $display("FAIL s2_ar: got %h/%0d want 2038/1", obs_araddr, obs_arid); end
        total++; if (obs_p2 !== 1 || obs_p1 !== 0 || obs_lat !== 10) begin bad++; $display("FAIL s2_pulse: got p1=%0d p2=%0d lat=%0d want 0 1 10", obs_p1, obs_p2, obs_lat); end
        total++; if (obs_line[448 +: 64] !== 64'hB0 || obs_line[0 +: 64] !== 64'hB1) begin bad++; $display("FAIL s2_wrap_words: got w7=%h w0=%h want b0 b1", obs_line[448 +: 64], obs_line[0 +: 64]); end
        total++; if (obs_line !== expect_line(64'h2038)) begin bad++; $display("FAIL s2_line: got %h want %h", obs_line, expect_line(64'h2038)); end
    endtask

    task automatic test_contention();
        logic [63:0] a1, a2;
        bit exp_s2;
        do_reset();
        S1_R_ADDR_VALID = 1'b1;
        S2_R_ADDR_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = rand64();
            a2 = rand64();
            S1_R_ADDR = a1;
            S2_R_ADDR = a2;
            for (int k = 0; k < 8; k++) beat_data[k] = rand64();
`ifdef L2_ARB_RR_EN
            exp_s2 = (i % 2) == 0;
`else
            exp_s2 = 1'b1;
`endif
            run_fill(0, 1'b0, 8'h80, 1'b1);
            total++; if (obs_arid !== 13'(exp_s2)) begin bad++; $display("FAIL contend_grant%0d: got arid %0d want %0d", i, obs_arid, exp_s2); end
            total++; if (obs_araddr !== ((exp_s2 ? a2 : a1) & ~64'h7)) begin bad++; $display("FAIL contend_addr%0d: got %h want %h", i, obs_araddr, (exp_s2 ? a2 : a1) & ~64'h7); end
            total++; if (obs_p2 !== int'(exp_s2) || obs_p1 !== int'(!exp_s2)) begin bad++; $display("FAIL contend_pulse%0d: got %0d/%0d", i, obs_p1, obs_p2); end
            total++; if (obs_line !== expect_line(exp_s2 ? a2 : a1)) begin bad++; $display("FAIL contend_line%0d: got %h want %h", i, obs_line, expect_line(exp_s2 ? a2 : a1)); end
        end
        S1_R_ADDR_VALID = 1'b0;
        S2_R_ADDR_VALID = 1'b0;
    endtask

    task automatic test_stalls();
        for (int k = 0; k < 8; k++) beat_data[k] = rand64();
        S1_R_ADDR = 64'h3010;
        S1_R_ADDR_VALID = 1'b1;
        run_fill(5, 1'b1, 8'h80, 1'b0);
        total++; if (!obs_stable || obs_timeout) begin bad++; $display("FAIL stall_stable: got stable=%0b timeout=%0b want 1 0", obs_stable, obs_timeout); end
        total++; if (obs_araddr !== 64'h3010 || obs_p1 !== 1 || obs_p2 !== 0) begin bad++; $display("FAIL stall_ar_pulse: got %h p1=%0d p2=%0d", obs_araddr, obs_p1, obs_p2); end
        total++; if (obs_line !== expect_line(64'h3010)) begin bad++; $display("FAIL stall_line: got %h want %h", obs_line, expect_line(64'h3010)); end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL stall_err: got %0b want 0", protocol_err); end
    endtask

    task automatic test_rlast_err();
        for (int k = 0; k < 8; k++) beat_data[k] = rand64();
        S2_R_ADDR = 64'h5020;
        S2_R_ADDR_VALID = 1'b1;
        run_fill(0, 1'b0, 8'h08, 1'b0);
        total++; if (obs_p2 !== 1 || obs_line !== expect_line(64'h5020)) begin bad++; $display("FAIL rlast_complete: got p2=%0d line %h", obs_p2, obs_line); end
        total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL rlast_err_set: got %0b want 1", protocol_err); end
        for (int k = 0; k < 8; k++) beat_data[k] = rand64();
        S1_R_ADDR = 64'h6000;
        S1_R_ADDR_VALID = 1'b1;
        run_fill(0, 1'b0, 8'h80, 1'b0);
        total++; if (protocol_err !== 1'b1 || obs_p1 !== 1) begin bad++; $display("FAIL rlast_err_sticky: got err=%0b p1=%0d want 1 1", protocol_err, obs_p1); end
    endtask

    task automatic test_reset_mid_burst();
        int p = 0;
        int w = 0;
        for (int k = 0; k < 8; k++) beat_data[k] = rand64();
        S1_R_ADDR = 64'h1048;
        S1_R_ADDR_VALID = 1'b1;
        while (!m_axi_arvalid && w < 20) begin @(negedge clk); w++; end
        total++; if (m_axi_arvalid !== 1'b1) begin bad++; $display("FAIL midrst_ar: got arvalid %0b want 1", m_axi_arvalid); end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = beat_data[k]; m_axi_rlast = 1'b0;
            @(negedge clk);
        end
        reset = 1'b1;
        S1_R_ADDR_VALID = 1'b0;
        #1;
        total++; if (m_axi_rready !== 1'b0 || m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL midrst_handshake: got rready=%0b arvalid=%0b want 0 0", m_axi_rready, m_axi_arvalid); end
        total++; if (S1_R_DATA !== '0 || protocol_err !== 1'b0) begin bad++; $display("FAIL midrst_clear: got data %h err %0b want 0", S1_R_DATA, protocol_err); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (S1_R_DATA_VALID === 1'b1 || S2_R_DATA_VALID === 1'b1) p++;
            @(negedge clk);
        end
        m_axi_rvalid = 1'b0;
        total++; if (p !== 0) begin bad++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", p); end
        for (int k = 0; k < 8; k++) beat_data[k] = rand64();
        S1_R_ADDR = 64'h1048;
        S1_R_ADDR_VALID = 1'b1;
        run_fill(0, 1'b0, 8'h80, 1'b0);
        total++; if (obs_lat !== 10 || obs_p1 !== 1) begin bad++; $display("FAIL midrst_restart: got lat=%0d p1=%0d want 10 1", obs_lat, obs_p1); end
        total++; if (obs_line !== expect_line(64'h1048) || protocol_err !== 1'b0) begin bad++; $display("FAIL midrst_line: got %h err %0b", obs_line, protocol_err); end
    endtask

    task automatic test_random();
        logic [63:0] a1, a2, ea;
        int mode;
        bit exp_s2;
        bit last_s2 = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mode = $urandom_range(0, 2);
            a1 = rand64();
            a2 = rand64();
            for (int k = 0; k < 8; k++) beat_data[k] = rand64();
            if (mode == 0) exp_s2 = 1'b0;
            else if (mode == 1) exp_s2 = 1'b1;
`ifdef L2_ARB_RR_EN
            else exp_s2 = !last_s2;
`else
            else exp_s2 = 1'b1;
`endif
            last_s2 = exp_s2;
            ea = exp_s2 ? a2 : a1;
            S1_R_ADDR = a1;
            S2_R_ADDR = a2;
            S1_R_ADDR_VALID = mode != 1;
            S2_R_ADDR_VALID = mode != 0;
            run_fill($urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'h80, 1'b0);
            total++; if (obs_timeout || obs_arid !== 13'(exp_s2) || obs_araddr !== (ea & ~64'h7)) begin bad++; $display("FAIL rand%0d_ar: got %h/%0d to=%0b want %h/%0d", i, obs_araddr, obs_arid, obs_timeout, ea & ~64'h7, exp_s2); end
            total++; if (obs_p2 !== int'(exp_s2) || obs_p1 !== int'(!exp_s2) || !obs_stable) begin bad++; $display("FAIL rand%0d_pulse: got p1=%0d p2=%0d stable=%0b", i, obs_p1, obs_p2, obs_stable); end
            total++; if (obs_line !== expect_line(ea)) begin bad++; $display("FAIL rand%0d_line: got %h want %h", i, obs_line, expect_line(ea)); end
            S1_R_ADDR_VALID = 1'b0;
            S2_R_ADDR_VALID = 1'b0;
        end
        total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL rand_err: got %0b want 0", protocol_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_s1_only();
        test_s2_wrap();
        test_contention();
        test_stalls();
        test_rlast_err();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
